// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared op/size encodings, IO base default and FSM state type for mem_ctrl
package mem_ctrl_pkg;

    localparam logic        OP_LOAD         = 1'b0;
    localparam logic        OP_STORE        = 1'b1;

    localparam logic [2:0]  SIZE_BYTE       = 3'b001;
    localparam logic [2:0]  SIZE_HALF       = 3'b010;
    localparam logic [2:0]  SIZE_WORD       = 3'b100;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Number of bytes moved for a size code; unknown codes move a full word.
    function automatic logic [2:0] size_to_bytes(input logic [2:0] size);
        case (size)
            SIZE_BYTE: size_to_bytes = 3'd1;
            SIZE_HALF: size_to_bytes = 3'd2;
            SIZE_WORD: size_to_bytes = 3'd4;
            default:   size_to_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO controller for IF and LSB clients; MEM_CTRL_IO_STALL_EN enables IO write back-pressure
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_flag,

    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_success,
    output logic [31:0] if_data,

    input  logic        lsb_enable,
    input  logic [2:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic        lsb_wr_tag,
    output logic        lsb_success,
    output logic [31:0] lsb_rdata,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q,       state_d;
    logic [2:0]  cnt_q,         cnt_d;
    logic [2:0]  nbytes_q,      nbytes_d;
    logic        lsb_client_q,  lsb_client_d;
    logic [31:0] wdata_q,       wdata_d;
    logic [31:0] rbuf_q,        rbuf_d;
    logic        cap_held_q,    cap_held_d;
    logic [31:0] mem_a_q,       mem_a_d;
    logic [7:0]  mem_dout_q,    mem_dout_d;
    logic        mem_wr_q,      mem_wr_d;
    logic        if_success_q,  if_success_d;
    logic        lsb_success_q, lsb_success_d;
    logic [31:0] if_data_q,     if_data_d;
    logic [31:0] lsb_rdata_q,   lsb_rdata_d;

    logic        io_stall;
    logic        cap_due;
    logic [1:0]  cap_idx;
    logic [31:0] rbuf_cap;
    logic [31:0] rbuf_new;
    logic        accept_store;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = (state_q == ST_WRITE) && io_buffer_full && (mem_a_q >= IO_BASE);
`else
    logic unused_io;
    assign io_stall  = 1'b0;
    assign unused_io = io_buffer_full ^ (IO_BASE == 32'h0);
`endif

    // The write strobe drops immediately while frozen or stalled; the rest of the state simply holds.
    assign mem_wr      = mem_wr_q & rdy & ~io_stall;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign if_success  = if_success_q;
    assign if_data     = if_data_q;
    assign lsb_success = lsb_success_q;
    assign lsb_rdata   = lsb_rdata_q;

    // Next-state logic: accept, issue one byte address per cycle, collect read bytes one cycle later.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nbytes_d      = nbytes_q;
        lsb_client_d  = lsb_client_q;
        wdata_d       = wdata_q;
        rbuf_d        = rbuf_q;
        cap_held_d    = cap_held_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;
        if_success_d  = if_success_q;
        lsb_success_d = lsb_success_q;
        if_data_d     = if_data_q;
        lsb_rdata_d   = lsb_rdata_q;

        // Byte returned by RAM this cycle belongs to the address issued two counts ago.
        cap_due  = (state_q == ST_READ) && (cnt_q >= 3'd2);
        cap_idx  = cnt_q[1:0] - 2'd2;
        rbuf_cap = rbuf_q;
        rbuf_cap[{cap_idx, 3'b000} +: 8] = mem_din;
        // A byte already grabbed during a freeze must not be overwritten by the stale RAM output.
        rbuf_new = cap_held_q ? rbuf_q : rbuf_cap;

        accept_store = lsb_enable && (lsb_wr_tag == OP_STORE);

        if (!rdy) begin
            // The RAM keeps running while we are frozen, so the due byte is only valid on the first frozen cycle.
            if (cap_due && !cap_held_q) begin
                rbuf_d     = rbuf_cap;
                cap_held_d = 1'b1;
            end
        end else begin
            if_success_d  = 1'b0;
            lsb_success_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_a_d    = 32'h0;
                    mem_wr_d   = 1'b0;
                    cnt_d      = 3'd0;
                    cap_held_d = 1'b0;
                    if (!jump_flag && (lsb_enable || if_enable)) begin
                        lsb_client_d = lsb_enable;
                        nbytes_d     = lsb_enable ? size_to_bytes(lsb_size) : 3'd4;
                        wdata_d      = lsb_wdata;
                        mem_a_d      = lsb_enable ? lsb_addr : if_addr;
                        mem_dout_d   = accept_store ? lsb_wdata[7:0] : 8'h00;
                        mem_wr_d     = accept_store;
                        cnt_d        = 3'd1;
                        rbuf_d       = 32'h0;
                        state_d      = accept_store ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (jump_flag) begin
                        state_d    = ST_IDLE;
                        mem_a_d    = 32'h0;
                        cnt_d      = 3'd0;
                        cap_held_d = 1'b0;
                    end else begin
                        if (cap_due) begin
                            rbuf_d = rbuf_new;
                        end
                        cap_held_d = 1'b0;
                        if (cnt_q == nbytes_q + 3'd1) begin
                            state_d = ST_DONE;
                            cnt_d   = 3'd0;
                            mem_a_d = 32'h0;
                            if (lsb_client_q) begin
                                lsb_rdata_d   = rbuf_new;
                                lsb_success_d = 1'b1;
                            end else begin
                                if_data_d     = rbuf_new;
                                if_success_d  = 1'b1;
                            end
                        end else if (cnt_q == nbytes_q) begin
                            mem_a_d = 32'h0;
                            cnt_d   = cnt_q + 3'd1;
                        end else begin
                            mem_a_d = mem_a_q + 32'h1;
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Stores ignore jump_flag: the LSB is waiting for the acknowledge.
                    if (!io_stall) begin
                        if (cnt_q == nbytes_q) begin
                            state_d       = ST_DONE;
                            cnt_d         = 3'd0;
                            mem_a_d       = 32'h0;
                            mem_dout_d    = 8'h00;
                            mem_wr_d      = 1'b0;
                            lsb_success_d = 1'b1;
                        end else begin
                            mem_a_d    = mem_a_q + 32'h1;
                            mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                            cnt_d      = cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    mem_a_d = 32'h0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset wins over rdy and drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            nbytes_q      <= 3'd0;
            lsb_client_q  <= 1'b0;
            wdata_q       <= 32'h0;
            rbuf_q        <= 32'h0;
            cap_held_q    <= 1'b0;
            mem_a_q       <= 32'h0;
            mem_dout_q    <= 8'h00;
            mem_wr_q      <= 1'b0;
            if_success_q  <= 1'b0;
            lsb_success_q <= 1'b0;
            if_data_q     <= 32'h0;
            lsb_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nbytes_q      <= nbytes_d;
            lsb_client_q  <= lsb_client_d;
            wdata_q       <= wdata_d;
            rbuf_q        <= rbuf_d;
            cap_held_q    <= cap_held_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            if_success_q  <= if_success_d;
            lsb_success_q <= lsb_success_d;
            if_data_q     <= if_data_d;
            lsb_rdata_q   <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized and directed self-checking bench for mem_ctrl
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_flag;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_success;
    logic [31:0] if_data;
    logic        lsb_enable;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata;
    logic        lsb_wr_tag;
    logic        lsb_success;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
        .if_enable(if_enable), .if_addr(if_addr), .if_success(if_success), .if_data(if_data),
        .lsb_enable(lsb_enable), .lsb_size(lsb_size), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_wr_tag(lsb_wr_tag), .lsb_success(lsb_success), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        return v;
    endfunction

    function automatic int nbytes(input logic [2:0] size);
        return (size == 3'b001) ? 1 : (size == 3'b010) ? 2 : 4;
    endfunction

    // Byte-wide RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wr_cnt++;
        end
        mem_din <= ram_rd(mem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_ram[a] = b;
    endtask

    function automatic logic [31:0] acks();
        return {30'b0, if_success, lsb_success};
    endfunction

    // One complete transaction presented in an idle cycle; returns with the DUT idle again.
    task automatic run_txn(input bit is_if, input bit st, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd, input bit jump_mid);
        int n;
        n = is_if ? 4 : nbytes(size);
        if (is_if) begin
            if_enable = 1'b1; if_addr = addr;
        end else begin
            lsb_enable = 1'b1; lsb_addr = addr; lsb_size = size; lsb_wr_tag = st; lsb_wdata = wd;
        end
        tick();
        if_enable = 1'b0; lsb_enable = 1'b0;
        if_addr = $urandom; lsb_addr = $urandom; lsb_wdata = $urandom; lsb_size = 3'($urandom);
        for (int k = 1; k <= n; k++) begin
            if (jump_mid && k >= 2) jump_flag = 1'b1;
            #1;
            check("byte_addr", mem_a, addr + 32'(k - 1));
            check("byte_wr", {31'b0, mem_wr}, {31'b0, st});
            if (st) check("byte_dout", 32'(mem_dout), 32'(wd[8*(k-1) +: 8]));
            check("early_ack", acks(), 32'd0);
            tick();
        end
        if (st) begin
            check("store_ack", acks(), 32'd1);
            for (int i = 0; i < n; i++) ref_ram[addr + 32'(i)] = wd[8*i +: 8];
            tick();
            jump_flag = 1'b0;
            check("store_ack_once", acks(), 32'd0);
            check("idle_addr", mem_a, 32'h0);
        end else begin
            check("read_wait", acks(), 32'd0);
            tick();
            check("read_ack", acks(), is_if ? 32'd2 : 32'd1);
            check("read_data", is_if ? if_data : lsb_rdata, exp_load(addr, n));
            tick();
            check("read_ack_once", acks(), 32'd0);
        end
        jump_flag = 1'b0;
    endtask

    initial begin : main
        logic [2:0]  sizes [3];
        logic [31:0] a1, a8, got_l, got_i, a;
        int lsb_cyc, if_cyc, if_cnt, ack_cnt, ack_cyc, wr_seen, wr_in_stall, w0, n_ack;
        int starts [4];
        sizes = '{3'b001, 3'b010, 3'b100};
        starts = '{2, 4, 5, 2};

        rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = 32'h0;
        lsb_enable = 1'b0; lsb_size = 3'b100; lsb_addr = 32'h0; lsb_wdata = 32'h0; lsb_wr_tag = 1'b0;
        repeat (3) tick();
        check("rst_if_success", {31'b0, if_success}, 32'd0);
        check("rst_lsb_success", {31'b0, lsb_success}, 32'd0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_lsb_rdata", lsb_rdata, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        rst = 1'b0;
        tick();

        // LW at 0x100 over known bytes, then SB 0x20.
        preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        run_txn(1'b0, 1'b0, 3'b100, 32'h100, 32'h0, 1'b0);
        check("lw_word", lsb_rdata, 32'h4433_2211);
        run_txn(1'b0, 1'b1, 3'b001, 32'h20, 32'h0000_00ab, 1'b0);
        check("sb_ram", 32'(ram_rd(32'h20)), 32'h0000_00ab);

        // LSB and IF requested together: LSB first, IF right after DONE.
        if_enable = 1'b1; if_addr = 32'h300;
        lsb_enable = 1'b1; lsb_addr = 32'h200; lsb_size = 3'b100; lsb_wr_tag = 1'b0;
        lsb_cyc = -1; if_cyc = -1; if_cnt = 0; a1 = 32'h0; a8 = 32'h0; got_l = 32'h0; got_i = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) begin lsb_enable = 1'b0; a1 = mem_a; end
            if (c == 8) begin if_enable = 1'b0; a8 = mem_a; end
            if (lsb_success) begin lsb_cyc = c; got_l = lsb_rdata; end
            if (if_success)  begin if_cnt++; if_cyc = c; got_i = if_data; end
        end
        check("prio_lsb_addr", a1, 32'h200);
        check("prio_lsb_cycle", 32'(lsb_cyc), 32'd6);
        check("prio_if_addr", a8, 32'h300);
        check("prio_if_cycle", 32'(if_cyc), 32'd13);
        check("prio_if_once", 32'(if_cnt), 32'd1);
        check("prio_lsb_data", got_l, exp_load(32'h200, 4));
        check("prio_if_data", got_i, exp_load(32'h300, 4));

        // Flush during an IF read: no ack, idle next cycle, new request two cycles later.
        if_enable = 1'b1; if_addr = 32'h0;
        n_ack = 0;
        tick();
        if_enable = 1'b0;
        n_ack += int'(if_success);
        tick();
        jump_flag = 1'b1;
        n_ack += int'(if_success);
        tick();
        jump_flag = 1'b0;
        n_ack += int'(if_success);
        check("flush_idle_addr", mem_a, 32'h0);
        tick();
        n_ack += int'(if_success);
        check("flush_no_ack", 32'(n_ack), 32'd0);
        run_txn(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);

        // Flush in IDLE accepts nothing.
        jump_flag = 1'b1; if_enable = 1'b1; if_addr = 32'h1234;
        tick();
        jump_flag = 1'b0; if_enable = 1'b0;
        check("jump_idle_addr", mem_a, 32'h0);
        tick();
        check("jump_idle_ack", acks(), 32'd0);

        // Flush during a store: store completes and is acknowledged.
        run_txn(1'b0, 1'b1, 3'b100, 32'h50, 32'hcafe_f00d, 1'b1);
        run_txn(1'b0, 1'b0, 3'b100, 32'h50, 32'h0, 1'b0);

        // SW into IO space with the IO buffer full for three cycles.
        w0 = wr_cnt; wr_seen = 0; wr_in_stall = 0; ack_cnt = 0; ack_cyc = -1;
        lsb_enable = 1'b1; lsb_addr = 32'h0003_0000; lsb_size = 3'b100; lsb_wr_tag = 1'b1; lsb_wdata = 32'hdead_beef;
        tick();
        lsb_enable = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            io_buffer_full = (c <= 3);
            #1;
            if (mem_wr) begin wr_seen++; if (c <= 3) wr_in_stall++; end
            if (lsb_success) begin ack_cnt++; ack_cyc = c; end
            tick();
        end
        io_buffer_full = 1'b0;
        for (int i = 0; i < 4; i++) ref_ram[32'h0003_0000 + 32'(i)] = 8'(32'hdead_beef >> (8*i));
`ifdef MEM_CTRL_IO_STALL_EN
        check("io_stall_wr", 32'(wr_in_stall), 32'd0);
        check("io_ack_cycle", 32'(ack_cyc), 32'd8);
`else
        check("io_nostall_wr", 32'(wr_in_stall), 32'd3);
        check("io_ack_cycle", 32'(ack_cyc), 32'd5);
`endif
        check("io_writes", 32'(wr_seen), 32'd4);
        check("io_ram_writes", 32'(wr_cnt - w0), 32'd4);
        check("io_ack_once", 32'(ack_cnt), 32'd1);
        run_txn(1'b0, 1'b0, 3'b100, 32'h0003_0000, 32'h0, 1'b0);

        // rdy low for two cycles at several points of a LW and a SW.
        for (int t = 0; t < 4; t++) begin
            a = 32'h400 + 32'(16 * t);
            w0 = wr_cnt; wr_seen = 0; ack_cnt = 0; ack_cyc = -1; got_l = 32'h0;
            lsb_enable = 1'b1; lsb_addr = a; lsb_size = 3'b100; lsb_wr_tag = (t == 3); lsb_wdata = 32'h1357_9bdf;
            tick();
            lsb_enable = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                rdy = !(c == starts[t] || c == starts[t] + 1);
                #1;
                if (mem_wr) wr_seen++;
                if (!rdy) check("frozen_wr", {31'b0, mem_wr}, 32'd0);
                if (lsb_success && rdy) begin ack_cnt++; ack_cyc = c; got_l = lsb_rdata; end
                tick();
            end
            rdy = 1'b1;
            check("rdy_ack_once", 32'(ack_cnt), 32'd1);
            if (t == 3) begin
                check("rdy_st_cycle", 32'(ack_cyc), 32'd7);
                check("rdy_st_writes", 32'(wr_cnt - w0), 32'd4);
                for (int i = 0; i < 4; i++) ref_ram[a + 32'(i)] = 8'(32'h1357_9bdf >> (8*i));
                run_txn(1'b0, 1'b0, 3'b100, a, 32'h0, 1'b0);
            end else begin
                check("rdy_ld_cycle", 32'(ack_cyc), 32'd8);
                check("rdy_ld_data", got_l, exp_load(a, 4));
                check("rdy_ld_nowr", 32'(wr_seen), 32'd0);
            end
        end

        // Reset in the middle of a store clears every output.
        lsb_enable = 1'b1; lsb_addr = 32'h600; lsb_size = 3'b100; lsb_wr_tag = 1'b1; lsb_wdata = 32'h89ab_cdef;
        tick();
        lsb_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_mid_mem_a", mem_a, 32'h0);
        check("rst_mid_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mid_acks", acks(), 32'd0);
        check("rst_mid_if_data", if_data, 32'h0);
        check("rst_mid_lsb_rdata", lsb_rdata, 32'h0);
        tick();
        check("rst_mid_dropped", mem_a, 32'h0);

        // Randomized traffic, including 32-bit wrap and the IO boundary.
        for (int i = 0; i < 60; i++) begin
            bit          is_if, st;
            logic [2:0]  sz;
            int          r;
            is_if = ($urandom_range(0, 2) == 0);
            st    = !is_if && ($urandom_range(0, 1) == 1);
            sz    = sizes[$urandom_range(0, 2)];
            r     = $urandom_range(0, 3);
            case (r)
                0:       a = 32'($urandom_range(0, 31));
                1:       a = 32'hffff_fffc + 32'($urandom_range(0, 3));
                2:       a = $urandom;
                default: a = 32'h0002_fffe + 32'($urandom_range(0, 3));
            endcase
            run_txn(is_if, st, sz, a, $urandom, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
